// File: rtl/store_align_unit_if.sv
// Store request / data-memory write bus bundle for store_align_unit.
// slave: the unit itself; master: the pipeline plus memory side driving it.
interface store_align_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        misalign_exc;
    logic [31:0] exc_badvaddr;
    logic        busy;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, flush, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
               misalign_exc, exc_badvaddr, busy
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, flush, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
               misalign_exc, exc_badvaddr, busy
    );
endinterface

// File: rtl/store_align_unit.sv
// Store lane formatter + store FIFO feeding the data-memory write port.
// Optional macro STORE_MISALIGN_EXC_EN: reject misaligned half/word stores with an exception pulse.
module store_align_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    store_align_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             entry_d;
    logic               accept, push, pop, misaligned;
    entry_t             head;

    // Lane formatting of the incoming store
    always_comb begin
        entry_d           = '0;
        entry_d.word_addr = bus.req_addr[31:2];
        misaligned        = 1'b0;
        case (bus.req_size)
            2'b00: begin
                entry_d.wdata = {4{bus.req_data[7:0]}};
                entry_d.wstrb = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                entry_d.wdata = {2{bus.req_data[15:0]}};
                entry_d.wstrb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                entry_d.wdata = bus.req_data;
                entry_d.wstrb = 4'b1111;
            end
        endcase
`ifdef STORE_MISALIGN_EXC_EN
        misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`endif
    end

    // Pointer / occupancy next state; flush keeps only a head that is not leaving
    always_comb begin
        accept   = bus.req_valid && (count_q != CNT_W'(DEPTH));
        pop      = (count_q != '0) && bus.mem_ready;
        push     = accept && !bus.flush && !misaligned;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (bus.flush) begin
            if ((count_q != '0) && !pop) begin
                count_d  = CNT_W'(1);
                wr_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                count_d  = '0;
                wr_ptr_d = rd_ptr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) fifo_q[wr_ptr_q] <= entry_d;
        end
    end

`ifdef STORE_MISALIGN_EXC_EN
    logic        misalign_exc_q;
    logic [31:0] exc_badvaddr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_exc_q <= 1'b0;
            exc_badvaddr_q <= '0;
        end else begin
            misalign_exc_q <= accept && misaligned;
            if (accept && misaligned) exc_badvaddr_q <= bus.req_addr;
        end
    end

    assign bus.misalign_exc = misalign_exc_q;
    assign bus.exc_badvaddr = exc_badvaddr_q;
`else
    assign bus.misalign_exc = 1'b0;
    assign bus.exc_badvaddr = '0;
`endif

    assign head          = fifo_q[rd_ptr_q];
    assign bus.req_ready = (count_q != CNT_W'(DEPTH));
    assign bus.mem_valid = (count_q != '0);
    assign bus.busy      = (count_q != '0);
    assign bus.mem_addr  = {head.word_addr, 2'b00};
    assign bus.mem_wdata = head.wdata;
    assign bus.mem_wstrb = head.wstrb;
endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit (DEPTH=2), covering both settings of STORE_MISALIGN_EXC_EN.
module tb_store_align_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] byte_strb [4];

    store_align_unit_if bus ();

    store_align_unit #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] size);
        bus.req_valid = v;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_size  = size;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        byte_strb[0] = 4'b0001; byte_strb[1] = 4'b0010;
        byte_strb[2] = 4'b0100; byte_strb[3] = 4'b1000;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        tick(); tick();
        rst = 1'b0;

        // reset state
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        check("rst_misalign", 32'(bus.misalign_exc), 32'd0);
        check("rst_badvaddr", bus.exc_badvaddr, 32'h0);

        // 1: sb at lane 3
        bus.mem_ready = 1'b1;
        drive(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("sb_valid", 32'(bus.mem_valid), 32'd1);
        check("sb_addr", bus.mem_addr, 32'h0000_1000);
        check("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        check("sb_wstrb", 32'(bus.mem_wstrb), 32'b1000);
        tick();
        check("sb_drained", 32'(bus.mem_valid), 32'd0);

        // 2: sh upper half, then sw pushed while sh pops
        drive(1'b1, 32'h0000_2002, 32'h0000_1234, 2'b01);
        tick();
        check("sh_wdata", bus.mem_wdata, 32'h1234_1234);
        check("sh_wstrb", 32'(bus.mem_wstrb), 32'b1100);
        check("sh_addr", bus.mem_addr, 32'h0000_2000);
        drive(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("sw_addr", bus.mem_addr, 32'h0000_2004);
        check("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("sw_wstrb", 32'(bus.mem_wstrb), 32'b1111);
        check("sw_busy", 32'(bus.busy), 32'd1);
        tick();
        check("sw_drained", 32'(bus.busy), 32'd0);

        // byte lanes 0..3 streamed back-to-back
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_0100 + 32'(i), 32'h0000_005A, 2'b00);
            tick();
            check("sb_lane_wstrb", 32'(bus.mem_wstrb), 32'(byte_strb[i]));
            check("sb_lane_wdata", bus.mem_wdata, 32'h5A5A_5A5A);
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        tick();

        // 3: back-pressure with three stores
        bus.mem_ready = 1'b0;
        drive(1'b1, 32'h0000_4000, 32'h1111_1111, 2'b10);
        tick();
        check("bp_ready_1", 32'(bus.req_ready), 32'd1);
        drive(1'b1, 32'h0000_4004, 32'h2222_2222, 2'b10);
        tick();
        check("bp_ready_full", 32'(bus.req_ready), 32'd0);
        drive(1'b1, 32'h0000_4008, 32'h3333_3333, 2'b10);
        tick();
        check("bp_ready_held", 32'(bus.req_ready), 32'd0);
        check("bp_head_addr", bus.mem_addr, 32'h0000_4000);
        check("bp_head_data", bus.mem_wdata, 32'h1111_1111);
        bus.mem_ready = 1'b1;
        tick();
        check("bp_second_addr", bus.mem_addr, 32'h0000_4004);
        check("bp_ready_back", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("bp_third_addr", bus.mem_addr, 32'h0000_4008);
        check("bp_third_data", bus.mem_wdata, 32'h3333_3333);
        tick();
        check("bp_drained", 32'(bus.busy), 32'd0);
        check("bp_ready_end", 32'(bus.req_ready), 32'd1);

        // 4: flush while full, new request in the same cycle
        bus.mem_ready = 1'b0;
        drive(1'b1, 32'h0000_5000, 32'hAAAA_0001, 2'b10);
        tick();
        drive(1'b1, 32'h0000_5004, 32'hAAAA_0002, 2'b10);
        tick();
        drive(1'b1, 32'h0000_5008, 32'hAAAA_0003, 2'b10);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("fl_busy", 32'(bus.busy), 32'd1);
        check("fl_ready", 32'(bus.req_ready), 32'd1);
        check("fl_head_addr", bus.mem_addr, 32'h0000_5000);
        bus.mem_ready = 1'b1;
        tick();
        check("fl_drained", 32'(bus.busy), 32'd0);

        // flush drops a store accepted in the flush cycle
        bus.mem_ready = 1'b0;
        drive(1'b1, 32'h0000_6000, 32'hBBBB_0001, 2'b10);
        tick();
        drive(1'b1, 32'h0000_6004, 32'hBBBB_0002, 2'b10);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("fla_head_addr", bus.mem_addr, 32'h0000_6000);
        bus.mem_ready = 1'b1;
        tick();
        check("fla_drained", 32'(bus.busy), 32'd0);

        // flush while the head pops: empty afterwards
        bus.mem_ready = 1'b0;
        drive(1'b1, 32'h0000_7000, 32'hCCCC_0001, 2'b10);
        tick();
        drive(1'b1, 32'h0000_7004, 32'hCCCC_0002, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        bus.mem_ready = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flp_valid", 32'(bus.mem_valid), 32'd0);
        check("flp_busy", 32'(bus.busy), 32'd0);

        // 5: misaligned word store
        drive(1'b1, 32'h0000_3001, 32'h0BAD_F00D, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
`ifdef STORE_MISALIGN_EXC_EN
        check("mis_exc", 32'(bus.misalign_exc), 32'd1);
        check("mis_badvaddr", bus.exc_badvaddr, 32'h0000_3001);
        check("mis_no_valid", 32'(bus.mem_valid), 32'd0);
        tick();
        check("mis_exc_pulse", 32'(bus.misalign_exc), 32'd0);
        check("mis_badvaddr_hold", bus.exc_badvaddr, 32'h0000_3001);
`else
        check("mis_valid", 32'(bus.mem_valid), 32'd1);
        check("mis_addr", bus.mem_addr, 32'h0000_3000);
        check("mis_wstrb", 32'(bus.mem_wstrb), 32'b1111);
        check("mis_exc_tied", 32'(bus.misalign_exc), 32'd0);
        check("mis_badvaddr_zero", bus.exc_badvaddr, 32'h0);
        drive(1'b1, 32'h0000_3003, 32'h0000_BEEF, 2'b01);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("mis_half_wstrb", 32'(bus.mem_wstrb), 32'b1100);
        check("mis_half_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
        tick();
`endif
        check("mis_drained", 32'(bus.busy), 32'd0);

        // 6: reset while full and presenting
        bus.mem_ready = 1'b0;
        drive(1'b1, 32'h0000_8000, 32'hDDDD_0001, 2'b10);
        tick();
        drive(1'b1, 32'h0000_8004, 32'hDDDD_0002, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("rf_full", 32'(bus.req_ready), 32'd0);
        check("rf_valid", 32'(bus.mem_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rf_valid_after", 32'(bus.mem_valid), 32'd0);
        check("rf_busy_after", 32'(bus.busy), 32'd0);
        check("rf_ready_after", 32'(bus.req_ready), 32'd1);
        check("rf_addr_after", bus.mem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
